// File: rtl/gpr_wb_sched_pkg.sv
// Shared constants for the GPR write-back path: register geometry, active-low
// enable encoding and requester indices used by the round-robin pointer.
package gpr_wb_sched_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;
  localparam int DATA_WIDTH     = 32;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [0:0] {
    WB_REQ_ALU = 1'b0,
    WB_REQ_LD  = 1'b1
  } wb_req_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set by decode allocation, cleared by the write
// port, with busy lookups that forward a same-cycle write.
module gpr_scoreboard
  import gpr_wb_sched_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int NUM    = REG_NUM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              gpr_we_,
  input  logic [ADDR_W-1:0] gpr_wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              rd_busy_0,
  output logic              rd_busy_1
);

  localparam logic [NUM-1:0] ONE_HOT_0 = {{(NUM-1){1'b0}}, 1'b1};

  logic [NUM-1:0] pending_r;
  logic [NUM-1:0] set_vec_s;
  logic [NUM-1:0] clr_vec_s;
  logic [NUM-1:0] pending_next_s;
  logic           wr_active_s;

  assign wr_active_s = (gpr_we_ == ENABLE_);

  // Set is applied after clear so a newer producer keeps the register pending
  always_comb begin
    set_vec_s      = alloc_valid ? (ONE_HOT_0 << alloc_addr) : {NUM{1'b0}};
    clr_vec_s      = wr_active_s ? (ONE_HOT_0 << gpr_wr_addr) : {NUM{1'b0}};
    pending_next_s = set_vec_s | (pending_r & ~clr_vec_s);
  end

  // Pending vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {NUM{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Busy lookups, masked by the write currently on the port
  always_comb begin
    rd_busy_0 = pending_r[rd_addr_0] && !(wr_active_s && (gpr_wr_addr == rd_addr_0));
    rd_busy_1 = pending_r[rd_addr_1] && !(wr_active_s && (gpr_wr_addr == rd_addr_1));
  end

endmodule

// File: rtl/gpr_wb_sched.sv
// Round-robin write-back scheduler sharing the register file's single write
// port between the ALU (req0) and load unit (req1), with a registered port.
module gpr_wb_sched
  import gpr_wb_sched_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int NUM    = REG_NUM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              rd_busy_0,
  output logic              rd_busy_1,
  output logic              gpr_we_,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data
);

  wb_req_e rr_ptr_r;
  wb_req_e rr_ptr_next_s;
  logic    grant0_s;
  logic    grant1_s;

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= WB_REQ_ALU;
    end else begin
      rr_ptr_r <= rr_ptr_next_s;
    end
  end

  // Pointer hands priority to the other requester after any grant
  always_comb begin
    if (grant0_s) begin
      rr_ptr_next_s = WB_REQ_LD;
    end else if (grant1_s) begin
      rr_ptr_next_s = WB_REQ_ALU;
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
  end

  // Grant decode; the output stage drains every cycle so it never back-pressures
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: grant0_s = 1'b1;
      2'b10: grant1_s = 1'b1;
      2'b11: begin
        if (rr_ptr_r == WB_REQ_ALU) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Write-port register: one cycle after acceptance; addr/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_we_     <= DISABLE_;
      gpr_wr_addr <= {ADDR_W{1'b0}};
      gpr_wr_data <= {DATA_W{1'b0}};
    end else if (grant0_s) begin
      gpr_we_     <= ENABLE_;
      gpr_wr_addr <= req0_addr;
      gpr_wr_data <= req0_data;
    end else if (grant1_s) begin
      gpr_we_     <= ENABLE_;
      gpr_wr_addr <= req1_addr;
      gpr_wr_data <= req1_data;
    end else begin
      gpr_we_     <= DISABLE_;
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM    (NUM)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .gpr_we_     (gpr_we_),
    .gpr_wr_addr (gpr_wr_addr),
    .rd_addr_0   (rd_addr_0),
    .rd_addr_1   (rd_addr_1),
    .rd_busy_0   (rd_busy_0),
    .rd_busy_1   (rd_busy_1)
  );

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched: inputs change on the falling edge and
// outputs are checked 1 time unit later, away from the rising edge.
module tb_gpr_wb_sched;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic [4:0]  rd_addr_0;
  logic [4:0]  rd_addr_1;
  logic        rd_busy_0;
  logic        rd_busy_1;
  logic        gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  int vectors;
  int miscompares;

  gpr_wb_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rd_addr_0   (rd_addr_0),
    .rd_addr_1   (rd_addr_1),
    .rd_busy_0   (rd_busy_0),
    .rd_busy_1   (rd_busy_1),
    .gpr_we_     (gpr_we_),
    .gpr_wr_addr (gpr_wr_addr),
    .gpr_wr_data (gpr_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, gpr_we_}, 32'd0);
    check({tag, "_addr"}, {27'd0, gpr_wr_addr}, {27'd0, a});
    check({tag, "_data"}, gpr_wr_data, d);
  endtask

  logic [31:0] d0;
  logic [31:0] d1;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req0_valid  = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid  = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    alloc_valid = 1'b0; alloc_addr = 5'd0;
    rd_addr_0   = 5'd0; rd_addr_1 = 5'd0;

    // Reset for two cycles
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", {31'd0, gpr_we_}, 32'd1);
    check("rst_addr", {27'd0, gpr_wr_addr}, 32'd0);
    check("rst_data", gpr_wr_data, 32'd0);
    check("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_0 = i[4:0];
      rd_addr_1 = 5'(31 - i);
      #1;
      check("rst_busy0", {31'd0, rd_busy_0}, 32'd0);
      check("rst_busy1", {31'd0, rd_busy_1}, 32'd0);
    end
    reset = 1'b0;

    // Single ALU request
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("single_rdy0", {31'd0, req0_ready}, 32'd1);
    check("single_rdy1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_port("single_wr", 5'd5, 32'hDEADBEEF);
    check("single_idle_rdy0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("single_we_off", {31'd0, gpr_we_}, 32'd1);
    check("single_hold_addr", {27'd0, gpr_wr_addr}, 32'd5);
    check("single_hold_data", gpr_wr_data, 32'hDEADBEEF);

    // Single load request; pointer then returns to req0
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hA5A5A5A5;
    #1;
    check("ld_rdy1", {31'd0, req1_ready}, 32'd1);
    check("ld_rdy0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check_port("ld_wr", 5'd2, 32'hA5A5A5A5);

    // Contention: grants 0,1,0,1 with back-to-back writes
    d0 = 32'h100;
    d1 = 32'h200;
    prev_addr = 5'd0;
    prev_data = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = d0;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = d1;
      #1;
      if (k > 0) check_port("cont_wr", prev_addr, prev_data);
      check("cont_rdy0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_rdy1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        prev_addr = 5'd1; prev_data = d0; d0 = d0 + 32'd1;
      end else begin
        prev_addr = 5'd2; prev_data = d1; d1 = d1 + 32'd1;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_port("cont_last", 5'd2, 32'h201);
    @(negedge clk);
    #1;
    check("cont_drain_we", {31'd0, gpr_we_}, 32'd1);

    // Scoreboard set, forward window, clear
    @(negedge clk);
    alloc_valid = 1'b1; alloc_addr = 5'd7; rd_addr_0 = 5'd7; rd_addr_1 = 5'd7;
    #1;
    check("sb_before", {31'd0, rd_busy_0}, 32'd0);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1;
    check("sb_set0", {31'd0, rd_busy_0}, 32'd1);
    check("sb_set1", {31'd0, rd_busy_1}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    #1;
    check("sb_ld_rdy", {31'd0, req1_ready}, 32'd1);
    check("sb_still", {31'd0, rd_busy_0}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check_port("sb_wr", 5'd7, 32'h77);
    check("sb_fwd0", {31'd0, rd_busy_0}, 32'd0);
    check("sb_fwd1", {31'd0, rd_busy_1}, 32'd0);
    @(negedge clk);
    #1;
    check("sb_clr0", {31'd0, rd_busy_0}, 32'd0);
    check("sb_clr1", {31'd0, rd_busy_1}, 32'd0);

    // Set and clear of the same register in one cycle: set wins
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    alloc_valid = 1'b1; alloc_addr = 5'd3; rd_addr_0 = 5'd3;
    #1;
    check("col_rdy0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_port("col_wr", 5'd3, 32'h33);
    check("col_fwd", {31'd0, rd_busy_0}, 32'd0);
    @(negedge clk);
    alloc_valid = 1'b0;
    #1;
    check("col_kept", {31'd0, rd_busy_0}, 32'd1);

    // Same address from both requesters; req1 first to put the pointer on req0
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h0;
    #1;
    check("same_pre_rdy1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    #1;
    check_port("same_pre_wr", 5'd10, 32'h0);
    @(negedge clk);
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h22;
    rd_addr_0 = 5'd9;
    #1;
    check("same_rdy0", {31'd0, req0_ready}, 32'd1);
    check("same_rdy1", {31'd0, req1_ready}, 32'd0);
    check("same_busy", {31'd0, rd_busy_0}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_port("same_wr1", 5'd9, 32'h11);
    check("same_rdy1b", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check_port("same_wr2", 5'd9, 32'h22);
    @(negedge clk);
    #1;
    check("same_final_we", {31'd0, gpr_we_}, 32'd1);
    check("same_final_data", gpr_wr_data, 32'h22);
    check("same_busy_clr", {31'd0, rd_busy_0}, 32'd0);

    // Reset during an accepted transfer discards it and clears state
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    alloc_valid = 1'b1; alloc_addr = 5'd12;
    rd_addr_1 = 5'd3; rd_addr_0 = 5'd12;
    reset = 1'b1;
    #1;
    check("mid_busy_pre", {31'd0, rd_busy_1}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0; alloc_valid = 1'b0;
    #1;
    check("mid_we", {31'd0, gpr_we_}, 32'd1);
    check("mid_addr", {27'd0, gpr_wr_addr}, 32'd0);
    check("mid_data", gpr_wr_data, 32'd0);
    check("mid_busy1", {31'd0, rd_busy_1}, 32'd0);
    check("mid_busy0", {31'd0, rd_busy_0}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    #1;
    check("mid_ptr_rdy0", {31'd0, req0_ready}, 32'd1);
    check("mid_ptr_rdy1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_port("mid_after_wr", 5'd6, 32'h66);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
